// File: rtl/frame_defs_pkg.sv
// Shared frame-format definitions for the frame assembler / deframer pair:
// deframer state encoding and default stream widths.
package frame_defs_pkg;
    typedef enum logic [1:0] {
        ST_PAYLOAD = 2'd0,
        ST_META    = 2'd1,
        ST_COUNT   = 2'd2,
        ST_DROP    = 2'd3
    } frame_state_e;

    localparam int DEF_DW         = 128;
    localparam int DEF_META_BEATS = 2;
    localparam int DEF_CNT_W      = 32;
endpackage

// File: rtl/frame_seq_checker.sv
// Frame-counter sequence checker, only built with FRAME_DEFRAMER_SEQ_CHECK_EN.
// The first capture after reset primes prev_cnt; later captures must be prev_cnt+1.
module frame_seq_checker #(
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cap_i,
    input  logic [DW-1:0] cnt_i,
    output logic          err_seq_o
);
    logic [DW-1:0] prev_cnt_q;
    logic          primed_q;
    logic          err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_cnt_q <= '0;
            primed_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= cap_i & primed_q & (cnt_i != prev_cnt_q + 1'b1);
            if (cap_i) begin
                prev_cnt_q <= cnt_i;
                primed_q   <= 1'b1;
            end
        end
    end

    assign err_seq_o = err_q;
endmodule

// File: rtl/frame_deframer.sv
// Splits a framed stream (payload, metadata, counter beat with tlast) into payload and
// metadata streams, captures the frame counter and flags length errors, resyncing on tlast.
// Define FRAME_DEFRAMER_SEQ_CHECK_EN to also check that frame counters increment by one.
module frame_deframer
    import frame_defs_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int META_BEATS = DEF_META_BEATS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [CNT_W-1:0] cfg_payload_beats,
    input  logic [DW-1:0]    s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [DW-1:0]    m_pay_tdata,
    output logic             m_pay_tvalid,
    input  logic             m_pay_tready,
    output logic             m_pay_tlast,
    output logic [DW-1:0]    m_meta_tdata,
    output logic             m_meta_tvalid,
    input  logic             m_meta_tready,
    output logic             m_meta_tlast,
    output logic [DW-1:0]    frame_cnt,
    output logic             frame_cnt_vld,
    output logic             err_len,
    output logic             err_seq
);
    localparam logic [CNT_W-1:0] META_LAST = (META_BEATS > 0) ? CNT_W'(META_BEATS - 1) : '0;

    frame_state_e     state_q;
    logic [CNT_W-1:0] beat_cnt_q, cfg_q;
    logic [DW-1:0]    frame_cnt_q;
    logic             frame_cnt_vld_q, err_len_q;

    logic [CNT_W-1:0] cfg_eff, pay_lim, beat_inc;
    logic             pay_last, meta_last, acc;

    // The first payload beat of a frame uses the live config; later beats the latched copy.
    assign cfg_eff   = (cfg_payload_beats == '0) ? CNT_W'(1) : cfg_payload_beats;
    assign pay_lim   = (beat_cnt_q == '0) ? cfg_eff : cfg_q;
    assign pay_last  = (beat_cnt_q == pay_lim - 1'b1);
    assign meta_last = (beat_cnt_q == META_LAST);
    assign beat_inc  = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;

    always_comb begin
        s_axis_tready = 1'b1;
        case (state_q)
            ST_PAYLOAD: s_axis_tready = m_pay_tready;
            ST_META:    s_axis_tready = m_meta_tready;
            default:    s_axis_tready = 1'b1;
        endcase
        s_axis_tready = s_axis_tready & resetn;
    end

    assign acc           = s_axis_tvalid & s_axis_tready;
    assign m_pay_tdata   = s_axis_tdata;
    assign m_meta_tdata  = s_axis_tdata;
    assign m_pay_tvalid  = resetn & s_axis_tvalid & (state_q == ST_PAYLOAD);
    assign m_meta_tvalid = resetn & s_axis_tvalid & (state_q == ST_META);
    assign m_pay_tlast   = s_axis_tlast | pay_last;
    assign m_meta_tlast  = s_axis_tlast | meta_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_PAYLOAD;
            beat_cnt_q      <= '0;
            cfg_q           <= CNT_W'(1);
            frame_cnt_q     <= '0;
            frame_cnt_vld_q <= 1'b0;
            err_len_q       <= 1'b0;
        end else begin
            frame_cnt_vld_q <= 1'b0;
            err_len_q       <= 1'b0;
            if (acc) begin
                case (state_q)
                    ST_PAYLOAD: begin
                        if (beat_cnt_q == '0) cfg_q <= cfg_eff;
                        if (s_axis_tlast) begin
                            err_len_q  <= 1'b1;
                            beat_cnt_q <= '0;
                        end else if (pay_last) begin
                            beat_cnt_q <= '0;
                            state_q    <= (META_BEATS > 0) ? ST_META : ST_COUNT;
                        end else begin
                            beat_cnt_q <= beat_inc;
                        end
                    end
                    ST_META: begin
                        if (s_axis_tlast) begin
                            err_len_q  <= 1'b1;
                            beat_cnt_q <= '0;
                            state_q    <= ST_PAYLOAD;
                        end else if (meta_last) begin
                            beat_cnt_q <= '0;
                            state_q    <= ST_COUNT;
                        end else begin
                            beat_cnt_q <= beat_inc;
                        end
                    end
                    ST_COUNT: begin
                        frame_cnt_q     <= s_axis_tdata;
                        frame_cnt_vld_q <= 1'b1;
                        if (s_axis_tlast) begin
                            state_q <= ST_PAYLOAD;
                        end else begin
                            err_len_q <= 1'b1;
                            state_q   <= ST_DROP;
                        end
                    end
                    default: begin
                        if (s_axis_tlast) state_q <= ST_PAYLOAD;
                    end
                endcase
            end
        end
    end

    assign frame_cnt     = frame_cnt_q;
    assign frame_cnt_vld = frame_cnt_vld_q;
    assign err_len       = err_len_q;

`ifdef FRAME_DEFRAMER_SEQ_CHECK_EN
    frame_seq_checker #(.DW(DW)) u_seq (
        .clk       (clk),
        .resetn    (resetn),
        .cap_i     (acc & (state_q == ST_COUNT)),
        .cnt_i     (s_axis_tdata),
        .err_seq_o (err_seq)
    );
`else
    assign err_seq = 1'b0;
`endif
endmodule
